// File: rtl/vga_timing_monitor.sv
// Reconstructs pixel/line position from VGA syncs, locks after clean frames, flags timing errors.
// Outputs update one Clk after each pixel tick; no backpressure (pure observer of Clk-synchronous video).
module vga_timing_monitor #(
    parameter int H_ACTIVE     = 640,
    parameter int H_TOTAL      = 800,
    parameter int H_SYNC_START = 656,
    parameter int V_ACTIVE     = 480,
    parameter int V_TOTAL      = 525,
    parameter int V_SYNC_START = 490,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        pixel_clk,
    input  logic        hs,
    input  logic        vs,
    input  logic        blank,
    input  logic        err_clr,
    output logic [9:0]  RxX,
    output logic [9:0]  RxY,
    output logic        locked,
    output logic        frame_tick,
    output logic [2:0]  err_flags,
    output logic [15:0] err_count
);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SS   = 10'(H_SYNC_START);
    localparam logic [9:0] V_SS   = 10'(V_SYNC_START);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [7:0] LOCK_LAST = 8'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

    state_t      state, state_nxt;
    logic        pclk_q, hs_q, vs_q;
    logic        tick, hs_fall, vs_fall, x_wrap, checking;
    logic [9:0]  x_inc, y_inc, y_adv, x_nxt, y_nxt;
    logic        line_err, frame_err, blank_err, err_any;
    logic [1:0]  n_err;
    logic [16:0] cnt_sum;
    logic [15:0] err_cnt_q;
    logic [7:0]  clean_cnt, clean_nxt;
    logic        dirty, dirty_nxt, first_vs, first_nxt;

    assign tick     = pixel_clk & ~pclk_q;
    assign hs_fall  = tick & hs_q & ~hs;
    assign vs_fall  = tick & vs_q & ~vs;
    assign x_wrap   = (RxX == H_LAST);
    assign x_inc    = x_wrap ? 10'd0 : RxX + 10'd1;
    assign y_inc    = (RxY == V_LAST) ? 10'd0 : RxY + 10'd1;
    // A sync-forced reload of RxX is not a wrap, so it never advances the line.
    assign y_adv    = (x_wrap && !hs_fall) ? y_inc : RxY;
    assign x_nxt    = hs_fall ? H_SS : x_inc;
    assign y_nxt    = vs_fall ? V_SS : y_adv;
    assign checking = (state != UNLOCKED);

    assign line_err  = hs_fall && checking && (x_inc != H_SS);
    assign frame_err = vs_fall && checking && !first_vs && (y_adv != V_SS);
    assign blank_err = tick && (state == LOCKED) &&
                       (blank != ((x_nxt < H_ACT) && (y_nxt < V_ACT)));
    assign err_any   = line_err | frame_err | blank_err;
    assign n_err     = {1'b0, line_err} + {1'b0, frame_err} + {1'b0, blank_err};
    assign cnt_sum   = {1'b0, err_cnt_q} + {15'd0, n_err};

    assign locked    = (state == LOCKED);
    assign err_count = err_cnt_q;

    always_comb begin
        state_nxt = state;
        clean_nxt = clean_cnt;
        dirty_nxt = dirty;
        first_nxt = first_vs;
        case (state)
            UNLOCKED: begin
                if (vs_fall) begin
                    state_nxt = ACQUIRE;
                    clean_nxt = 8'd0;
                    dirty_nxt = 1'b0;
                    first_nxt = 1'b1;
                end
            end
            ACQUIRE: begin
                // A frame counts as clean only if nothing went wrong between its two vs falls.
                if (vs_fall) begin
                    first_nxt = 1'b0;
                    dirty_nxt = 1'b0;
                    if (err_any || dirty) begin
                        clean_nxt = 8'd0;
                    end else if (clean_cnt == LOCK_LAST) begin
                        state_nxt = LOCKED;
                        clean_nxt = 8'd0;
                    end else begin
                        clean_nxt = clean_cnt + 8'd1;
                    end
                end else if (err_any) begin
                    clean_nxt = 8'd0;
                    dirty_nxt = 1'b1;
                end
            end
            LOCKED: begin
                if (err_any) begin
                    state_nxt = ACQUIRE;
                    clean_nxt = 8'd0;
                    dirty_nxt = !vs_fall;
                    first_nxt = 1'b1;
                end
            end
            default: state_nxt = UNLOCKED;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pclk_q     <= 1'b0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            RxX        <= 10'd0;
            RxY        <= 10'd0;
            state      <= UNLOCKED;
            clean_cnt  <= 8'd0;
            dirty      <= 1'b0;
            first_vs   <= 1'b0;
            frame_tick <= 1'b0;
            err_flags  <= 3'd0;
            err_cnt_q  <= 16'd0;
        end else begin
            pclk_q     <= pixel_clk;
            frame_tick <= vs_fall;
            state      <= state_nxt;
            clean_cnt  <= clean_nxt;
            dirty      <= dirty_nxt;
            first_vs   <= first_nxt;
            if (tick) begin
                hs_q <= hs;
                vs_q <= vs;
                RxX  <= x_nxt;
                RxY  <= y_nxt;
            end
            if (err_clr) begin
                err_flags <= 3'd0;
                err_cnt_q <= 16'd0;
            end else if (err_any) begin
                err_flags <= err_flags | {frame_err, line_err, blank_err};
                err_cnt_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
            end
        end
    end
endmodule
